// File: rtl/output_sram_writeback.sv
// output_sram_writeback: drains output SRAM port B to DRAM over the CSn/RASn/CASn/WEn command bus
module output_sram_writeback #(
    parameter int TRCD  = 2,
    parameter int TRP   = 2,
    parameter int BANKS = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_start,
    input  logic [16:0]             Output_SRAM_ADDR_start,
    input  logic [16:0]             Output_SRAM_ADDR_end,
    input  logic [31:0]             DRAM_ADDR_start,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic [BANKS-1:0][11:0]  output_SRAM_AB_DMA,
    output logic                    output_SRAM_CEN_DMA,
    output logic                    output_SRAM_OEN_DMA,
    input  logic [BANKS-1:0][31:0]  output_SRAM_DO_DMA,
    output logic                    DRAM_CSn,
    output logic                    DRAM_RASn,
    output logic                    DRAM_CASn,
    output logic [3:0]              DRAM_WEn,
    output logic [12:0]             DRAM_A,
    output logic [31:0]             DRAM_D
);
    typedef enum logic [2:0] {IDLE, ACT, RCD, WRITE, PRE, PRE_LAST} state_t;
    state_t state, state_n;
    logic [22:0] w, w_n;
    logic [17:0] left, left_n;
    logic [3:0]  cnt, cnt_n;
    logic [16:0] rd_idx, idx_cur;
    logic [11:0] ab;
    logic [4:0]  rd_bank, bank_q;
    logic [31:0] d_q;
    logic        cen, empty, rd_issue;
    logic        unused;
    assign unused = ^{DRAM_ADDR_start[31:25], DRAM_ADDR_start[1:0]};
    assign empty = Output_SRAM_ADDR_end < Output_SRAM_ADDR_start;
    assign idx_cur = (state == IDLE) ? Output_SRAM_ADDR_start : rd_idx;
    assign output_SRAM_AB_DMA = {BANKS{ab}};
    assign output_SRAM_CEN_DMA = cen;
    assign output_SRAM_OEN_DMA = cen;
    // data for the word being written arrives from the read issued one cycle earlier
    assign DRAM_D = DRAM_CASn ? d_q : output_SRAM_DO_DMA[bank_q];
    // next-state selection
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = (wb_start && !empty) ? ACT : IDLE;
            ACT:      state_n = (TRCD > 1) ? RCD : WRITE;
            RCD:      state_n = (cnt == 4'd0) ? WRITE : RCD;
            WRITE:    state_n = (left == 18'd1) ? PRE_LAST : ((w[9:0] == 10'h3ff) ? PRE : WRITE);
            PRE:      state_n = (cnt == 4'd0) ? ACT : PRE;
            PRE_LAST: state_n = (cnt == 4'd0) ? IDLE : PRE_LAST;
            default:  state_n = IDLE;
        endcase
    end
    // next word address, remaining count, wait counter and SRAM read decision
    always_comb begin
        w_n = (state == IDLE) ? DRAM_ADDR_start[24:2] : ((state == WRITE) ? w + 23'd1 : w);
        left_n = (state == IDLE) ? 18'(Output_SRAM_ADDR_end) - 18'(Output_SRAM_ADDR_start) + 18'd1
               : ((state == WRITE) ? left - 18'd1 : left);
        cnt_n = (state_n != state) ? ((state_n == RCD) ? 4'(TRCD - 2) : 4'(TRP - 1)) : cnt - 4'd1;
        rd_issue = (state_n == RCD && cnt_n == 4'd0) || (state_n == ACT && TRCD == 1)
                || (state_n == WRITE && left_n != 18'd1 && w_n[9:0] != 10'h3ff);
    end
    // state register
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_n;
    end
    // registered datapath and command outputs, driven from the upcoming state
    always_ff @(posedge clk) begin
        if (!rst) begin
            w <= '0;
            left <= '0;
            cnt <= '0;
            rd_idx <= '0;
            ab <= '0;
            rd_bank <= '0;
            bank_q <= '0;
            cen <= 1'b1;
            DRAM_CSn <= 1'b1;
            DRAM_RASn <= 1'b1;
            DRAM_CASn <= 1'b1;
            DRAM_WEn <= 4'hF;
            DRAM_A <= '0;
            d_q <= '0;
            wb_busy <= 1'b0;
            wb_done <= 1'b0;
        end else begin
            w <= w_n;
            left <= left_n;
            cnt <= cnt_n;
            rd_idx <= rd_issue ? idx_cur + 17'd1 : idx_cur;
            ab <= rd_issue ? idx_cur[16:5] : ab;
            rd_bank <= rd_issue ? idx_cur[4:0] : rd_bank;
            bank_q <= rd_bank;
            cen <= !rd_issue;
            DRAM_CSn <= state_n == IDLE;
            DRAM_RASn <= !(state_n == ACT || state_n == RCD || state_n == WRITE);
            DRAM_CASn <= state_n != WRITE;
            DRAM_WEn <= (state_n == WRITE) ? 4'h0 : 4'hF;
            DRAM_A <= (state_n == ACT) ? w_n[22:10] : ((state_n == WRITE) ? {3'b000, w_n[9:0]} : DRAM_A);
            d_q <= DRAM_D;
            wb_busy <= state_n != IDLE;
            wb_done <= (state == PRE_LAST && cnt == 4'd0) || (state == IDLE && wb_start && empty);
        end
    end
endmodule

// File: tb/tb_output_sram_writeback.sv
// tb_output_sram_writeback: vector table, corner sequences and random transfers against a row/latency model
module tb_output_sram_writeback;
    logic clk = 0, rst = 0, wb_start = 0;
    logic [16:0] s_in = 0, e_in = 0;
    logic [31:0] d_in = 0;
    logic wb_busy, wb_done, cen, oen, csn, ras, cas;
    logic [31:0][11:0] ab;
    logic [31:0][31:0] sram_do = '0;
    logic [3:0] wen;
    logic [12:0] a;
    logic [31:0] d;
    int vectors = 0, miscompares = 0;

    output_sram_writeback dut (
        .clk(clk), .rst(rst), .wb_start(wb_start),
        .Output_SRAM_ADDR_start(s_in), .Output_SRAM_ADDR_end(e_in), .DRAM_ADDR_start(d_in),
        .wb_busy(wb_busy), .wb_done(wb_done),
        .output_SRAM_AB_DMA(ab), .output_SRAM_CEN_DMA(cen), .output_SRAM_OEN_DMA(oen),
        .output_SRAM_DO_DMA(sram_do),
        .DRAM_CSn(csn), .DRAM_RASn(ras), .DRAM_CASn(cas), .DRAM_WEn(wen), .DRAM_A(a), .DRAM_D(d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [16:0] e);
        return ({15'h0, e} * 32'h9E3779B1) ^ 32'hC3A50F1E;
    endfunction

    // 32-bank SRAM with one-cycle read latency; element {addr, bank}
    always @(posedge clk) begin
        if (!cen) for (int b = 0; b < 32; b++) sram_do[b] <= dat({ab[b], 5'(b)});
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // latency and activate count from the row-splitting rule
    function automatic void model(input logic [16:0] s, input logic [16:0] e, input logic [31:0] da,
                                  output int lat, output int acts);
        int n, seg;
        logic [22:0] w;
        n = (e >= s) ? int'(e) - int'(s) + 1 : 0;
        lat = 1;
        acts = 0;
        w = da[24:2];
        while (n > 0) begin
            seg = 1024 - int'(w[9:0]);
            if (seg > n) seg = n;
            lat += 2 + seg + 2;
            acts++;
            w += 23'(seg);
            n -= seg;
        end
    endfunction

    task automatic run(input logic [16:0] s, input logic [16:0] e, input logic [31:0] da,
                       input int exp_lat, input int exp_acts, input int mid);
        int n, k, acts, done_at, busy_bad, idle_bad, proto_bad, extra;
        logic [12:0] row;
        logic prev_ras;
        logic [22:0] wk;
        n = (e >= s) ? int'(e) - int'(s) + 1 : 0;
        k = 0; acts = 0; done_at = 0; busy_bad = 0; idle_bad = 0; proto_bad = 0; extra = 0;
        row = 0; prev_ras = 1;
        @(negedge clk);
        s_in = s; e_in = e; d_in = da; wb_start = 1;
        for (int c = 1; c <= exp_lat + 50 && done_at == 0; c++) begin
            @(negedge clk);
            wb_start = (c == mid);
            s_in = 17'($urandom); e_in = 17'($urandom); d_in = $urandom;
            if (!ras && prev_ras) begin
                acts++;
                row = a;
            end
            prev_ras = ras;
            if (!cas) begin
                if (csn || ras || wen != 4'h0) proto_bad++;
                wk = da[24:2] + 23'(k);
                chk($sformatf("wr_addr[%0d]", k), {row, a}, {wk[22:10], 3'b000, wk[9:0]});
                chk($sformatf("wr_data[%0d]", k), d, dat(s + 17'(k)));
                k++;
            end
            if ((!cen || !oen) && ras) proto_bad++;
            if (n == 0 && (!csn || !ras || !cas || !cen)) idle_bad++;
            if (wb_done) done_at = c;
            else if (wb_busy != (n > 0)) busy_bad++;
        end
        wb_start = 0;
        chk("done_latency", done_at, exp_lat);
        chk("word_count", k, n);
        chk("activates", acts, exp_acts);
        chk("busy_at_done", wb_busy, 0);
        chk("busy_profile", busy_bad, 0);
        chk("protocol", proto_bad, 0);
        chk("zero_len_quiet", idle_bad, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_done || wb_busy) extra++;
        end
        chk("after_done", extra, 0);
    endtask

    typedef struct {
        logic [16:0] s, e;
        logic [31:0] da;
        int lat, acts, mid;
    } vec_t;

    initial begin
        vec_t tab[6];
        int lat, acts, saw_cas;
        logic [16:0] s, e;
        logic [31:0] da;
        tab[0] = '{17'd5, 17'd5, 32'h0020_0000, 6, 1, 0};
        tab[1] = '{17'd0, 17'd63, 32'h0, 69, 1, 0};
        tab[2] = '{17'd0, 17'd3, 32'h0000_0FF8, 13, 2, 0};
        tab[3] = '{17'd4, 17'd3, 32'h0000_0123, 1, 0, 0};
        tab[4] = '{17'd100, 17'd130, 32'h0000_1000, 36, 1, 10};
        tab[5] = '{17'h1FFF0, 17'h1FFFF, 32'hABCD_0FF0, 25, 2, 0};
        repeat (2) @(negedge clk);
        chk("rst_ctrl", {csn, ras, cas, wen, cen, oen, wb_busy, wb_done}, {3'b111, 4'hF, 2'b11, 2'b00});
        chk("rst_a", a, 0);
        chk("rst_d", d, 0);
        chk("rst_ab", |ab, 0);
        rst = 1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) run(tab[i].s, tab[i].e, tab[i].da, tab[i].lat, tab[i].acts, tab[i].mid);
        // reset in the middle of a write burst
        @(negedge clk);
        s_in = 0; e_in = 19; d_in = 32'h40; wb_start = 1;
        @(negedge clk);
        wb_start = 0;
        saw_cas = 0;
        for (int c = 0; c < 20 && saw_cas == 0; c++) begin
            @(negedge clk);
            if (!cas) saw_cas = 1;
        end
        chk("t6_in_write", saw_cas, 1);
        rst = 0;
        @(negedge clk);
        chk("t6_rst_ctrl", {csn, ras, cas, wen, cen, oen, wb_busy, wb_done}, {3'b111, 4'hF, 2'b11, 2'b00});
        chk("t6_rst_a", a, 0);
        chk("t6_rst_d", d, 0);
        chk("t6_rst_ab", |ab, 0);
        rst = 1;
        run(17'd7, 17'd9, 32'h0000_2000, 8, 1, 0);
        for (int i = 0; i < 20; i++) begin
            s = 17'($urandom);
            e = s + 17'($urandom_range(0, 40)) - 17'd1;
            da = $urandom;
            if ($urandom_range(0, 1) == 1) da[11:2] = 10'(1024 - $urandom_range(1, 20));
            model(s, e, da, lat, acts);
            run(s, e, da, lat, acts, (lat > 4) ? int'($urandom_range(2, 3)) : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
